// File: rtl/ymerge_pkg.sv
// ymerge_pkg: state encoding and run-length width helper shared by the
// two-way BRAM run merger and its per-run cursors.
package ymerge_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } merge_state_e;

  // A run can span the whole BRAM, so its length needs one bit more than an address.
  function automatic int runLenWidth(input int addrWidth);
    return addrWidth + 1;
  endfunction

endpackage

// File: rtl/merge_run_cursor.sv
// merge_run_cursor: read pointer and remaining count for one input run.
// Drives its BRAM port address so the registered read data always shows the
// element at the pointer. Optional build macro ORDER_CHECK_EN adds a sticky
// flag raised when this run delivers a key smaller than the one before it.
module merge_run_cursor
  import ymerge_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10,
  parameter int LEN_WIDTH  = runLenWidth(ADDR_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_load,
  input  logic [ADDR_WIDTH-1:0] i_base,
  input  logic [LEN_WIDTH-1:0]  i_len,
  input  logic                  i_consume,
  input  logic [DATA_WIDTH-1:0] i_dout,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic                  o_empty,
  output logic                  o_one,
  output logic                  o_orderErr
);

  logic [ADDR_WIDTH-1:0] r_ptr;
  logic [LEN_WIDTH-1:0]  r_rem;

  // Latch the run on launch, then step one element per consume (pointer wraps).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
      r_rem <= '0;
    end else if (i_load) begin
      r_ptr <= i_base;
      r_rem <= i_len;
    end else if (i_consume) begin
      r_ptr <= r_ptr + ADDR_WIDTH'(1);
      r_rem <= r_rem - LEN_WIDTH'(1);
    end
  end

  // Look one element ahead on consume so the next read lands with no bubble.
  assign o_addr  = i_load ? i_base : (i_consume ? r_ptr + ADDR_WIDTH'(1) : r_ptr);
  assign o_empty = (r_rem == '0);
  assign o_one   = (r_rem == LEN_WIDTH'(1));

`ifdef ORDER_CHECK_EN
  logic [DATA_WIDTH-1:0] r_lastKey;
  logic                  r_havePrev;
  logic                  r_orderErr;

  // Remember the last consumed key and flag any descent; cleared on launch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lastKey  <= '0;
      r_havePrev <= 1'b0;
      r_orderErr <= 1'b0;
    end else if (i_load) begin
      r_havePrev <= 1'b0;
      r_orderErr <= 1'b0;
    end else if (i_consume) begin
      r_lastKey  <= i_dout;
      r_havePrev <= 1'b1;
      if (r_havePrev && (i_dout < r_lastKey)) begin
        r_orderErr <= 1'b1;
      end
    end
  end

  assign o_orderErr = r_orderErr;
`else
  logic w_unusedDout;
  assign w_unusedDout = ^i_dout;
  assign o_orderErr   = 1'b0;
`endif

endmodule

// File: rtl/bram_run_merger.sv
// bram_run_merger: merges two ascending runs read from the two ports of a
// dual-port BRAM into one ascending valid/ready stream (ties favour run A).
// Optional build macro ORDER_CHECK_EN enables the unsorted-input flag.
module bram_run_merger
  import ymerge_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_a,
  input  logic [ADDR_WIDTH-1:0] base_b,
  input  logic [ADDR_WIDTH:0]   len_a,
  input  logic [ADDR_WIDTH:0]   len_b,
  output logic [ADDR_WIDTH-1:0] bram_addr_a,
  output logic [ADDR_WIDTH-1:0] bram_addr_b,
  output logic                  bram_we_a,
  output logic                  bram_we_b,
  input  logic [DATA_WIDTH-1:0] bram_dout_a,
  input  logic [DATA_WIDTH-1:0] bram_dout_b,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic                  order_err
);

  localparam int LEN_WIDTH = runLenWidth(ADDR_WIDTH);

  merge_state_e          r_state;
  merge_state_e          w_nextState;
  logic [DATA_WIDTH-1:0] r_outData;
  logic                  r_outValid;
  logic                  r_outLast;
  logic                  r_done;

  logic w_launch, w_slotFree, w_load, w_takeA, w_lastLoad;
  logic w_consumeA, w_consumeB;
  logic w_emptyA, w_emptyB, w_oneA, w_oneB, w_errA, w_errB;

  assign w_launch   = (r_state == IDLE) && start;
  assign w_slotFree = !r_outValid || out_ready;
  assign w_load     = (r_state == RUN) && w_slotFree;
  assign w_takeA    = !w_emptyA && (w_emptyB || (bram_dout_a <= bram_dout_b));
  assign w_consumeA = w_load && w_takeA;
  assign w_consumeB = w_load && !w_takeA;
  assign w_lastLoad = w_takeA ? (w_oneA && w_emptyB) : (w_oneB && w_emptyA);

  merge_run_cursor #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .LEN_WIDTH (LEN_WIDTH)
  ) u_cursorA (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_launch),
    .i_base    (base_a),
    .i_len     (len_a),
    .i_consume (w_consumeA),
    .i_dout    (bram_dout_a),
    .o_addr    (bram_addr_a),
    .o_empty   (w_emptyA),
    .o_one     (w_oneA),
    .o_orderErr(w_errA)
  );

  merge_run_cursor #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .LEN_WIDTH (LEN_WIDTH)
  ) u_cursorB (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_launch),
    .i_base    (base_b),
    .i_len     (len_b),
    .i_consume (w_consumeB),
    .i_dout    (bram_dout_b),
    .o_addr    (bram_addr_b),
    .o_empty   (w_emptyB),
    .o_one     (w_oneB),
    .o_orderErr(w_errB)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next state: an empty merge skips RUN; FLUSH waits for the last element to leave.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_nextState = ((len_a == '0) && (len_b == '0)) ? FLUSH : RUN;
        end
      end
      RUN: begin
        if (w_load && w_lastLoad) begin
          w_nextState = FLUSH;
        end
      end
      FLUSH: begin
        if (w_slotFree) begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Output slot: load the winning key when free, hold it while the sink stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outData  <= '0;
      r_outValid <= 1'b0;
      r_outLast  <= 1'b0;
    end else if (w_load) begin
      r_outData  <= w_takeA ? bram_dout_a : bram_dout_b;
      r_outValid <= 1'b1;
      r_outLast  <= w_lastLoad;
    end else if (out_ready) begin
      r_outValid <= 1'b0;
      r_outLast  <= 1'b0;
    end
  end

  // Completion pulse in the cycle after FLUSH is left.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done <= 1'b0;
    end else begin
      r_done <= (r_state == FLUSH) && w_slotFree;
    end
  end

  assign bram_we_a = 1'b0;
  assign bram_we_b = 1'b0;
  assign out_data  = r_outData;
  assign out_valid = r_outValid;
  assign out_last  = r_outLast;
  assign busy      = (r_state != IDLE);
  assign done      = r_done;
  assign order_err = w_errA || w_errB;

endmodule
